// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI mode-0 initiator. Sends one WIDTH-bit word MSB first on
//                mosi while capturing WIDTH bits from miso. spi_clk and cs_n
//                are derived from clk through a HALF_PERIOD divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
   parameter int HALF_PERIOD = 4,
   parameter int WIDTH       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rx_data,
   output logic             spi_clk,
   output logic             mosi,
   input  logic             miso,
   output logic             cs_n
);

   localparam int c_cnt_w = $clog2(HALF_PERIOD) + 1;
   localparam int c_bit_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_hp_last  = c_cnt_w'(HALF_PERIOD - 1);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

   localparam logic [2:0] c_idle = 3'd0;
   localparam logic [2:0] c_lead = 3'd1;
   localparam logic [2:0] c_high = 3'd2;
   localparam logic [2:0] c_low  = 3'd3;
   localparam logic [2:0] c_done = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_next;
   logic [c_cnt_w-1:0] r_hp_cnt;
   logic [c_bit_w-1:0] r_bit_cnt;
   logic [WIDTH-1:0]   r_tx_sh;
   logic [WIDTH-1:0]   r_rx_sh;
   logic [WIDTH-1:0]   r_rx_data;
   logic               w_hp_end;

   assign w_hp_end = (r_hp_cnt == c_hp_last);
   assign rx_data  = r_rx_data;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_idle;
      else     r_state <= w_next;
   end

   // Next-state decode: each timed phase lasts exactly HALF_PERIOD cycles
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (start)    w_next = c_lead;
         c_lead:  if (w_hp_end) w_next = c_high;
         c_high:  if (w_hp_end) w_next = c_low;
         c_low:   if (w_hp_end) w_next = (r_bit_cnt == c_bit_last) ? c_done : c_high;
         c_done:                w_next = c_idle;
         default:               w_next = c_idle;
      endcase
   end

   // Datapath: phase counter, bit counter, shifters and the rx_data holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hp_cnt  <= '0;
         r_bit_cnt <= '0;
         r_tx_sh   <= '0;
         r_rx_sh   <= '0;
         r_rx_data <= '0;
      end else begin
         // Counter restarts on every phase change and rests at zero outside timed phases
         if (w_next != r_state || r_state == c_idle || r_state == c_done)
            r_hp_cnt <= '0;
         else
            r_hp_cnt <= r_hp_cnt + 1'b1;

         if (r_state == c_idle && start) begin
            r_tx_sh   <= tx_data;
            r_rx_sh   <= '0;
            r_bit_cnt <= '0;
         end

         // Rising spi_clk edge: sample miso into the LSB
         if (w_next == c_high && r_state != c_high)
            r_rx_sh <= (r_rx_sh << 1) | WIDTH'(miso);

         // Falling spi_clk edge: present the next bit, except after the last one
         if (r_state == c_high && w_next == c_low && r_bit_cnt != c_bit_last)
            r_tx_sh <= r_tx_sh << 1;

         if (r_state == c_low && w_next == c_high)
            r_bit_cnt <= r_bit_cnt + 1'b1;

         // Publish the word on the same edge that enters DONE so it coincides with done
         if (r_state == c_low && w_next == c_done)
            r_rx_data <= r_rx_sh;
      end
   end

   // Output decode: all pin-level signals follow the state directly
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      spi_clk = 1'b0;
      mosi    = 1'b0;
      cs_n    = 1'b1;
      case (r_state)
         c_lead: begin
            busy = 1'b1;
            cs_n = 1'b0;
            mosi = r_tx_sh[WIDTH-1];
         end
         c_high: begin
            busy    = 1'b1;
            cs_n    = 1'b0;
            spi_clk = 1'b1;
            mosi    = r_tx_sh[WIDTH-1];
         end
         c_low: begin
            busy = 1'b1;
            cs_n = 1'b0;
            mosi = r_tx_sh[WIDTH-1];
         end
         c_done:  done = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench for spi_master (HALF_PERIOD=2 and =1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       busy, done, spi_clk, mosi, miso, cs_n;
   logic [7:0] rx_data;
   logic       loop = 1'b1;
   logic       tie = 1'b0;

   logic       start1 = 1'b0;
   logic [7:0] tx1 = 8'h00;
   logic       busy1, done1, spi_clk1, mosi1, cs_n1;
   logic [7:0] rx1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   int         rise_cnt = 0;
   int         done_cnt = 0;
   int         idle_err = 0;
   logic [7:0] mosi_sh = 8'h00;
   logic       prev_sck = 1'b0;

   always #5 clk = ~clk;

   assign miso = loop ? mosi : tie;

   spi_master #(.HALF_PERIOD(2), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
      .done(done), .rx_data(rx_data), .spi_clk(spi_clk), .mosi(mosi),
      .miso(miso), .cs_n(cs_n));

   spi_master #(.HALF_PERIOD(1), .WIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1),
      .done(done1), .rx_data(rx1), .spi_clk(spi_clk1), .mosi(mosi1),
      .miso(mosi1), .cs_n(cs_n1));

   // Pin monitor for the HALF_PERIOD=2 instance
   always @(negedge clk) begin
      if (spi_clk && !prev_sck) begin
         rise_cnt <= rise_cnt + 1;
         mosi_sh  <= {mosi_sh[6:0], mosi};
      end
      prev_sck <= spi_clk;
      if (done) done_cnt <= done_cnt + 1;
      if (cs_n && mosi) idle_err <= idle_err + 1;
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h want 00", rx_data); end
      n_tests++; if (spi_clk !== 1'b0)  begin n_fail++; $display("FAIL reset_sck: got %b want 0", spi_clk); end
      n_tests++; if (mosi !== 1'b0)     begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
      n_tests++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL reset_csn: got %b want 1", cs_n); end
      n_tests++; if (cs_n1 !== 1'b1 || rx1 !== 8'h00)
         begin n_fail++; $display("FAIL reset_dut1: got cs_n=%b rx=%h want 1/00", cs_n1, rx1); end
      rst = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic [7:0] exp_rx, input bit poke, input string nm);
      int lat, r0, d0;
      logic [7:0] e;
      exp_q.push_back(exp_rx);
      @(posedge clk); #1;
      start = 1'b1; tx_data = d;
      @(posedge clk); #1;
      start = 1'b0; tx_data = ~d;
      r0 = rise_cnt; d0 = done_cnt;
      n_tests++; if (busy !== 1'b1 || cs_n !== 1'b0)
         begin n_fail++; $display("FAIL %s_accept: got busy=%b cs_n=%b want 1/0", nm, busy, cs_n); end
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (poke) begin
            if (lat == 10) begin start = 1'b1; tx_data = 8'h55; end
            else if (lat == 11) start = 1'b0;
         end
      end
      n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL %s_latency: got %0d want 34", nm, lat); end
      e = exp_q.pop_front();
      n_tests++; if (rx_data !== e) begin n_fail++; $display("FAIL %s_rx: got %h want %h", nm, rx_data, e); end
      n_tests++; if (busy !== 1'b0 || cs_n !== 1'b1)
         begin n_fail++; $display("FAIL %s_done_pins: got busy=%b cs_n=%b want 0/1", nm, busy, cs_n); end
      n_tests++; if (mosi_sh !== d) begin n_fail++; $display("FAIL %s_mosi_bits: got %h want %h", nm, mosi_sh, d); end
      n_tests++; if (rise_cnt - r0 !== 8)
         begin n_fail++; $display("FAIL %s_rises: got %0d want 8", nm, rise_cnt - r0); end
      if (poke) begin
         repeat (10) @(posedge clk);
         #1;
         n_tests++; if (done_cnt - d0 !== 1)
            begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", nm, done_cnt - d0); end
      end
   endtask

   task automatic test_loopback();
      loop = 1'b1;
      run_frame(8'hCB, 8'hCB, 1'b0, "loopback");
   endtask

   task automatic test_tied();
      loop = 1'b0;
      tie  = 1'b1;
      run_frame(8'h00, 8'hFF, 1'b0, "tied1");
      tie  = 1'b0;
      run_frame(8'hFF, 8'h00, 1'b0, "tied0");
      loop = 1'b1;
      n_tests++; if (idle_err !== 0) begin n_fail++; $display("FAIL mosi_idle: got %0d cycles high want 0", idle_err); end
   endtask

   task automatic test_start_busy();
      loop = 1'b1;
      run_frame(8'hC3, 8'hC3, 1'b1, "start_busy");
   endtask

   task automatic test_back_to_back();
      int lat, n;
      logic [7:0] e;
      loop = 1'b1;
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h0F);
      @(posedge clk); #1;
      start = 1'b1; tx_data = 8'hF0;
      @(posedge clk); #1;
      tx_data = 8'h0F;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
      n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 34", lat); end
      e = exp_q.pop_front();
      n_tests++; if (rx_data !== e) begin n_fail++; $display("FAIL b2b_rx1: got %h want %h", rx_data, e); end
      n = 0;
      while (cs_n === 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      start = 1'b0;
      n_tests++; if (n !== 2) begin n_fail++; $display("FAIL b2b_csn_gap: got %0d want 2", n); end
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
      n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 34", lat); end
      e = exp_q.pop_front();
      n_tests++; if (rx_data !== e) begin n_fail++; $display("FAIL b2b_rx2: got %h want %h", rx_data, e); end
      n_tests++; if (mosi_sh !== 8'h0F) begin n_fail++; $display("FAIL b2b_mosi: got %h want 0f", mosi_sh); end
   endtask

   task automatic test_reset_mid();
      int r0, d0, k;
      loop = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; tx_data = 8'h96;
      @(posedge clk); #1;
      start = 1'b0;
      r0 = rise_cnt; d0 = done_cnt; k = 0;
      while (rise_cnt - r0 < 3 && k < 200) begin @(posedge clk); #1; k++; end
      n_tests++; if (k >= 200) begin n_fail++; $display("FAIL rstmid_rise3: got timeout want 3 rises"); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (cs_n !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_pins: got cs_n=%b sck=%b busy=%b mosi=%b done=%b want 1/0/0/0/0",
                                  cs_n, spi_clk, busy, mosi, done); end
      n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx: got %h want 00", rx_data); end
      rst = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
      run_frame(8'hA5, 8'hA5, 1'b0, "after_reset");
   endtask

   task automatic test_min_divider();
      int lat, tg;
      logic prev;
      logic [7:0] e;
      exp_q.push_back(8'h3C);
      @(posedge clk); #1;
      start1 = 1'b1; tx1 = 8'h3C;
      @(posedge clk); #1;
      start1 = 1'b0; tx1 = 8'h00;
      n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL hp1_accept: got busy=%b want 1", busy1); end
      lat = 0; tg = 0; prev = spi_clk1;
      while (done1 !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done1 !== 1'b1 && spi_clk1 !== prev) tg++;
         prev = spi_clk1;
      end
      n_tests++; if (lat !== 17) begin n_fail++; $display("FAIL hp1_latency: got %0d want 17", lat); end
      n_tests++; if (tg !== 16) begin n_fail++; $display("FAIL hp1_toggles: got %0d want 16", tg); end
      e = exp_q.pop_front();
      n_tests++; if (rx1 !== e) begin n_fail++; $display("FAIL hp1_rx: got %h want %h", rx1, e); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_tied();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      test_min_divider();
      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
